stage_if: RTL and testbench

//  Instruction-fetch stage: owns the PC and drives pc/inst into stage_id, and consumes br/br_addr back from it.

---
 rtl/stage_if_pkg.sv | 39 +++
 rtl/stage_if_if.sv | 17 +
 rtl/stage_if_icache.sv | 72 +++++++
 rtl/stage_if.sv | 116 +++++++++++
 tb/tb_stage_if.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   stall_bus_t    : stall controller bus; bit STALL_IF freezes IF, bit STALL_ID freezes ID
//   inst_bus_t     : 32-bit instruction word
//   mem_addr_bus_t : 32-bit byte address
//   fetch_state_e  : byte-serial fetch FSM states
//   byte_lane()    : which byte of the word a burst state collects
package stage_if_pkg;

  localparam int STALL_W  = 6;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  typedef logic [STALL_W-1:0] stall_bus_t;
  typedef logic [31:0]        inst_bus_t;
  typedef logic [31:0]        mem_addr_bus_t;

  // Opcode 0 decodes to a no-op downstream, so an all-zero word is a bubble.
  localparam inst_bus_t NOP_INST_DEFAULT = 32'h0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2,
    S_B3,
    S_DONE
  } fetch_state_e;

  // Instructions are little-endian: state Bk carries byte k.
  function automatic logic [1:0] byte_lane(input fetch_state_e s);
    case (s)
      S_B1:    return 2'd1;
      S_B2:    return 2'd2;
      S_B3:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stage_if_if.sv
// Byte-serial instruction-side memory port.
//   mem_req   : read request, held together with mem_addr until mem_ack
//   mem_addr  : byte address
//   mem_ack   : mem_rdata valid this cycle (meaningful only while mem_req=1)
//   mem_rdata : returned byte
// master = fetch stage, slave = memory controller.
interface stage_if_if;
  import stage_if_pkg::*;

  logic          mem_req;
  mem_addr_bus_t mem_addr;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/stage_if_icache.sv
// Direct-mapped, one-word-per-line instruction cache.
//   clk, reset        : clock, synchronous active-high reset (starts the clear sweep)
//   rd_pc             : lookup address; hit / rd_word are combinational
//   wr_en, wr_pc,
//   wr_word           : single write port, installs a line and marks it valid
// After reset the valid bits are cleared one line per cycle; hit is forced low
// until the sweep has covered every line.
module stage_if_icache
  import stage_if_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  mem_addr_bus_t rd_pc,
  output logic          hit,
  output inst_bus_t     rd_word,
  input  logic          wr_en,
  input  mem_addr_bus_t wr_pc,
  input  inst_bus_t     wr_word
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic [LINES-1:0] valid;
  tag_t             tag_mem  [LINES];
  inst_bus_t        word_mem [LINES];
  logic             clr_busy;
  idx_t             clr_idx;
  idx_t             rd_idx, wr_idx;
  tag_t             rd_tag, wr_tag;
  logic             unused_ok;

  assign rd_idx    = rd_pc[IDX_W+1:2];
  assign rd_tag    = rd_pc[31:IDX_W+2];
  assign wr_idx    = wr_pc[IDX_W+1:2];
  assign wr_tag    = wr_pc[31:IDX_W+2];
  assign unused_ok = ^{rd_pc[1:0], wr_pc[1:0]};

  assign hit     = !clr_busy && valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_word = word_mem[rd_idx];

  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_busy <= 1'b1;
      clr_idx  <= '0;
    end else if (clr_busy) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == idx_t'(LINES - 1)) clr_busy <= 1'b0;
    end
  end

  // NOTE: the valid bits and line storage have no reset term; the sweep
  // invalidates lines over time so the arrays can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (clr_busy) valid[clr_idx] <= 1'b0;
    if (wr_en)    valid[wr_idx]  <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      word_mem[wr_idx] <= wr_word;
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage.
//   clk, reset : clock, synchronous active-high reset
//   stall      : stall controller bus ([STALL_IF]=IF stalled, [STALL_ID]=ID stalled)
//   stall_if   : high while no instruction is ready
//   br/br_addr : redirect from stage_id (ignored while ID is stalled)
//   imem       : byte-serial memory port (master side)
//   pc, inst   : registered PC / instruction handed to stage_id
// Cache hits issue one word per cycle; misses collect four bytes (B0..B3),
// install the line and issue from DONE.
module stage_if
  import stage_if_pkg::*;
#(
  parameter int            ICACHE_LINES = 64,
  parameter mem_addr_bus_t RESET_PC     = 32'h0,
  parameter inst_bus_t     NOP_INST     = NOP_INST_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  stall_bus_t    stall,
  output logic          stall_if,
  input  logic          br,
  input  mem_addr_bus_t br_addr,
  stage_if_if.master    imem,
  output mem_addr_bus_t pc,
  output inst_bus_t     inst
);
  fetch_state_e  state, state_nxt;
  mem_addr_bus_t fetch_pc;
  mem_addr_bus_t mem_addr_q;
  inst_bus_t     word_buf, word, cache_word;
  logic          hit, ready, ack, in_burst, redirect, issue, fill_done;
  logic          unused_ok;

  assign unused_ok = ^{stall[STALL_W-1:STALL_ID+1], stall[0], br_addr[1:0]};

  stage_if_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk     (clk),
    .reset   (reset),
    .rd_pc   (fetch_pc),
    .hit     (hit),
    .rd_word (cache_word),
    .wr_en   (fill_done),
    .wr_pc   (fetch_pc),
    .wr_word ({imem.mem_rdata, word_buf[23:0]})
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!hit)  state_nxt = S_B0;
      S_B0:    if (ack)   state_nxt = S_B1;
      S_B1:    if (ack)   state_nxt = S_B2;
      S_B2:    if (ack)   state_nxt = S_B3;
      S_B3:    if (ack)   state_nxt = S_DONE;
      S_DONE:  if (issue) state_nxt = S_IDLE;
      default:            state_nxt = S_IDLE;
    endcase
    // A redirect abandons any fetch; the line is still installed if the
    // last byte arrives on the same edge (fill_done is not gated by br).
    if (redirect) state_nxt = S_IDLE;
  end

  always_comb begin
    in_burst  = state inside {S_B0, S_B1, S_B2, S_B3};
    ready     = (state == S_DONE) || ((state == S_IDLE) && hit);
    word      = (state == S_DONE) ? word_buf : cache_word;
    ack       = imem.mem_ack && in_burst;
    redirect  = br && !stall[STALL_ID];
    issue     = ready && !stall[STALL_ID] && !br && !stall[STALL_IF];
    fill_done = (state == S_B3) && ack && !reset;
    stall_if  = !ready && !reset;
  end

  assign imem.mem_req  = in_burst;
  assign imem.mem_addr = mem_addr_q;

  always_ff @(posedge clk) begin
    if (reset)                                       mem_addr_q <= '0;
    else if ((state == S_IDLE) && !hit && !redirect) mem_addr_q <= fetch_pc;
    else if (ack)                                    mem_addr_q <= mem_addr_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (ack) word_buf[{byte_lane(state), 3'b000} +: 8] <= imem.mem_rdata;
  end

  // An ID stall freezes pc/inst/fetch_pc while the FSM keeps fetching.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC & ~32'd3;
      pc       <= '0;
      inst     <= NOP_INST;
    end else if (!stall[STALL_ID]) begin
      if (br) begin
        fetch_pc <= {br_addr[31:2], 2'b00};
        pc       <= '0;
        inst     <= NOP_INST;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        pc       <= fetch_pc;
        inst     <= word;
      end else begin
        pc       <= '0;
        inst     <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_stage_if;
  import stage_if_pkg::*;

  localparam logic [31:0] NOP = 32'h0;

  logic       clk = 1'b0;
  logic       reset;
  stall_bus_t stall;
  logic       stall_if;
  logic       br;
  logic [31:0] br_addr;
  logic [31:0] pc, inst;

  stage_if_if bus ();

  stage_if #(.ICACHE_LINES(64), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .stall_if (stall_if),
    .br       (br),
    .br_addr  (br_addr),
    .imem     (bus.master),
    .pc       (pc),
    .inst     (inst)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: instruction memory, cache contents and fetch progress.
  logic [7:0]  mem_tbl [256];
  logic        c_valid [64];
  logic [23:0] c_tag   [64];
  logic [31:0] c_word  [64];
  logic [31:0] m_fpc, m_pc, m_inst, m_addr, m_buf;
  logic        m_req, m_busy, m_have;
  int          m_nacks, m_sweep;
  int          ack_mode;   // 0 never, 1 always, 2 random

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_tbl[8'(a + 32'd3)], mem_tbl[8'(a + 32'd2)],
            mem_tbl[8'(a + 32'd1)], mem_tbl[a[7:0]]};
  endfunction

  task automatic model_reset();
    m_fpc = 32'h0; m_pc = 32'h0; m_inst = NOP; m_addr = 32'h0; m_buf = 32'h0;
    m_req = 1'b0; m_busy = 1'b0; m_have = 1'b0; m_nacks = 0;
    m_sweep = 64;   // cache reports miss while every line is being invalidated
    for (int i = 0; i < 64; i++) c_valid[i] = 1'b0;
  endtask

  // One clock: drive memory side, compare outputs, advance the model.
  task automatic step();
    logic [5:0]  idx;
    logic [23:0] tg;
    logic        idle, hit, ready, ack;
    logic [31:0] word;
    case (ack_mode)
      0:       bus.mem_ack = 1'b0;
      1:       bus.mem_ack = 1'b1;
      default: bus.mem_ack = 1'($urandom_range(0, 1));
    endcase
    if (m_sweep > 0) bus.mem_ack = 1'b0;   // no line fills while the sweep runs
    bus.mem_rdata = mem_tbl[m_addr[7:0]];
    #1;
    idx   = m_fpc[7:2];
    tg    = m_fpc[31:8];
    idle  = !m_busy && !m_have;
    hit   = (m_sweep == 0) && c_valid[idx] && (c_tag[idx] == tg);
    ready = m_have || (idle && hit);
    word  = m_have ? m_buf : c_word[idx];
    chk("pc", pc, m_pc);
    chk("inst", inst, m_inst);
    chk("mem_req", 32'(bus.mem_req), 32'(m_req));
    if (m_req) chk("mem_addr", bus.mem_addr, m_addr);
    chk("stall_if", 32'(stall_if), 32'(!ready && !reset));
    if (reset) begin
      model_reset();
    end else begin
      ack = bus.mem_ack && m_req;
      if (m_busy && ack) begin
        m_buf[8*m_nacks +: 8] = bus.mem_rdata;
        m_nacks++;
        m_addr++;
        if (m_nacks == 4) begin
          m_busy = 1'b0; m_have = 1'b1; m_req = 1'b0;
          c_valid[idx] = 1'b1; c_tag[idx] = tg; c_word[idx] = m_buf;
        end
      end else if (idle && !hit) begin
        m_busy = 1'b1; m_nacks = 0; m_req = 1'b1; m_addr = m_fpc;
      end
      if (stall[STALL_ID]) begin
        // everything visible to ID is frozen; fetching continues above
      end else if (br) begin
        m_fpc = {br_addr[31:2], 2'b00}; m_inst = NOP; m_pc = 32'h0;
        m_busy = 1'b0; m_have = 1'b0; m_req = 1'b0;
      end else if (ready && !stall[STALL_IF]) begin
        m_pc = m_fpc; m_inst = word; m_fpc = m_fpc + 32'd4; m_have = 1'b0;
      end else begin
        m_inst = NOP; m_pc = 32'h0;
      end
      if (m_sweep > 0) m_sweep--;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = '0; br = 1'b0; br_addr = '0; ack_mode = 0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem_tbl[i] = 8'($urandom);
    mem_tbl[0] = 8'h13; mem_tbl[1] = 8'h05; mem_tbl[2] = 8'h10; mem_tbl[3] = 8'h00;
    model_reset();
    @(negedge clk);
    step(); step();
    reset = 1'b0;

    // First miss at 0x0 with acks withheld across the clear sweep.
    repeat (70) step();
    chk("wait_req", 32'(bus.mem_req), 32'd1);
    chk("wait_addr", bus.mem_addr, 32'h0);
    chk("wait_stall_if", 32'(stall_if), 32'd1);
    ack_mode = 1;
    step(); chk("addr1", bus.mem_addr, 32'h1);
    step(); chk("addr2", bus.mem_addr, 32'h2);
    step(); chk("addr3", bus.mem_addr, 32'h3);
    step();
    chk("done_stall_if", 32'(stall_if), 32'd0);
    chk("done_req", 32'(bus.mem_req), 32'd0);
    step();
    chk("first_inst", inst, 32'h00100513);
    chk("first_pc", pc, 32'h0);

    // Loop back (misaligned target truncates to 0x0): hit, no memory access.
    br = 1'b1; br_addr = 32'h2; step(); br = 1'b0;
    chk("hit_stall_if", 32'(stall_if), 32'd0);
    chk("hit_req", 32'(bus.mem_req), 32'd0);
    step();
    chk("hit_inst", inst, 32'h00100513);
    chk("hit_pc", pc, 32'h0);
    chk("hit_req2", 32'(bus.mem_req), 32'd0);

    // Miss at 0x8 aborted after two acks by a redirect to 0x40.
    br = 1'b1; br_addr = 32'h8; step(); br = 1'b0;
    step();
    chk("miss8_req", 32'(bus.mem_req), 32'd1);
    chk("miss8_addr", bus.mem_addr, 32'h8);
    step(); step();
    ack_mode = 0; br = 1'b1; br_addr = 32'h40; step(); br = 1'b0;
    chk("abort_req", 32'(bus.mem_req), 32'd0);
    chk("abort_inst", inst, NOP);
    step();
    chk("req40", 32'(bus.mem_req), 32'd1);
    chk("addr40", bus.mem_addr, 32'h40);
    ack_mode = 1;
    repeat (5) step();
    chk("inst40", inst, word_at(32'h40));
    chk("pc40", pc, 32'h40);

    // ID stall for 5 cycles across a whole miss; br inside it is ignored.
    stall[STALL_ID] = 1'b1;
    step(); step();
    br = 1'b1; br_addr = 32'h80; step(); br = 1'b0;
    step(); step();
    chk("stall_pc", pc, 32'h40);
    chk("stall_inst", inst, word_at(32'h40));
    stall = '0;
    chk("stall_done_ready", 32'(stall_if), 32'd0);
    step();
    chk("inst44", inst, word_at(32'h44));
    chk("pc44", pc, 32'h44);

    // 0x8 was never installed: it must miss.
    br = 1'b1; br_addr = 32'h8; step(); br = 1'b0;
    chk("miss8b_stall_if", 32'(stall_if), 32'd1);
    step();
    chk("miss8b_req", 32'(bus.mem_req), 32'd1);
    chk("miss8b_addr", bus.mem_addr, 32'h8);

    // Reset in B2 drops the request; afterwards previously cached 0x40 misses.
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_inst", inst, NOP);
    repeat (70) step();
    br = 1'b1; br_addr = 32'h40; step(); br = 1'b0;
    chk("post_rst_miss", 32'(stall_if), 32'd1);
    step();
    chk("post_rst_req", 32'(bus.mem_req), 32'd1);

    // Ack withheld for 10 cycles outside the sweep.
    ack_mode = 0;
    repeat (10) step();
    chk("hold_req", 32'(bus.mem_req), 32'd1);
    chk("hold_addr", bus.mem_addr, 32'h40);
    chk("hold_stall_if", 32'(stall_if), 32'd1);

    // Random traffic: acks, stalls, redirects (incl. wrap region), rare resets.
    ack_mode = 2;
    for (int n = 0; n < 600; n++) begin
      stall = stall_bus_t'($urandom) & 6'b111001;
      stall[STALL_ID] = ($urandom_range(0, 9) == 0);
      stall[STALL_IF] = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       br_addr = 32'hFFFF_FFF4 | ($urandom & 32'h7);
        1:       br_addr = $urandom;
        default: br_addr = $urandom & 32'h3FF;
      endcase
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; br = 1'b0; stall = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
